lsu_bank_xbar_rr: RTL

Parametrised address crossbar between the LSU address ports and the SRAM bank groups. Each LSU port sends a valid-tagged address whose top bits select a bank. Each bank has a round-robin arbiter that picks among the ports targeting it, in place of a fixed priority. The block issues a per-port grant, holds a registered address slot per bank with backpressure, reports which port won (for read-data return routing), and counts conflict stalls.

---
 rtl/lsu_bank_xbar_rr.sv | 119 +++++++++++
 1 files changed

// File: rtl/lsu_bank_xbar_rr.sv
// LSU-to-bank address crossbar: per-bank round-robin arbitration, one registered
// address slot per bank with backpressure, winner reporting and a saturating conflict counter.
`ifndef A_W
`define A_W 12
`endif

module lsu_bank_xbar_rr #(
    parameter int NUM_PORT = 8,
    parameter int NUM_BANK = 8,
    parameter int ADDR_W   = `A_W,
    parameter int SEL_W    = $clog2(NUM_BANK),
    parameter int PORT_W   = $clog2(NUM_PORT),
    parameter int CNT_W    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORT-1:0]               lsu_valid,
    input  logic [NUM_PORT*(SEL_W+ADDR_W)-1:0] lsu_addr_bus,
    output logic [NUM_PORT-1:0]               lsu_ready,
    input  logic [NUM_BANK-1:0]               bg_ready,
    output logic [NUM_BANK-1:0]               bg_valid,
    output logic [NUM_BANK*ADDR_W-1:0]        bg_addr,
    output logic [NUM_BANK*PORT_W-1:0]        bg_src,
    output logic [CNT_W-1:0]                  conflict_cnt
);

    localparam int SLICE_W = SEL_W + ADDR_W;
    localparam int LOSS_W  = PORT_W + 1;
    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic [SEL_W-1:0]  port_sel  [NUM_PORT];
    logic [ADDR_W-1:0] port_addr [NUM_PORT];
    logic [PORT_W-1:0] rr_ptr    [NUM_BANK];
    logic [PORT_W-1:0] grant_idx [NUM_BANK];
    logic [NUM_BANK-1:0] grant_any;
    logic [NUM_BANK-1:0] slot_free;
    logic [LOSS_W-1:0] loss_cnt;
    logic [CNT_W:0]    cnt_sum;

    always_comb begin
        for (int p = 0; p < NUM_PORT; p++) begin
            port_sel[p]  = lsu_addr_bus[p*SLICE_W+ADDR_W +: SEL_W];
            port_addr[p] = lsu_addr_bus[p*SLICE_W +: ADDR_W];
        end
    end

    // Scan ports starting at the bank's pointer with wrap; first requester wins.
    always_comb begin
        int                scan;
        logic [PORT_W-1:0] cand;
        logic              hit;
        scan = 0;
        cand = '0;
        hit  = 1'b0;
        for (int b = 0; b < NUM_BANK; b++) begin
            slot_free[b] = !bg_valid[b] || bg_ready[b];
            grant_idx[b] = '0;
            hit          = 1'b0;
            for (int k = 0; k < NUM_PORT; k++) begin
                scan = int'(rr_ptr[b]) + k;
                if (scan >= NUM_PORT) begin
                    scan = scan - NUM_PORT;
                end
                cand = PORT_W'(scan);
                if (!hit && lsu_valid[cand] && (port_sel[cand] == SEL_W'(b))) begin
                    hit          = 1'b1;
                    grant_idx[b] = cand;
                end
            end
            grant_any[b] = hit && slot_free[b] && !rst;
        end
    end

    always_comb begin
        lsu_ready = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            for (int b = 0; b < NUM_BANK; b++) begin
                if (grant_any[b] && (grant_idx[b] == PORT_W'(p))) begin
                    lsu_ready[p] = 1'b1;
                end
            end
        end
    end

    // Every valid-but-not-ready port this cycle is one lost request-cycle.
    always_comb begin
        loss_cnt = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            loss_cnt = loss_cnt + LOSS_W'(lsu_valid[p] && !lsu_ready[p]);
        end
        cnt_sum = {1'b0, conflict_cnt} + (CNT_W+1)'(loss_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bg_valid     <= '0;
            bg_addr      <= '0;
            bg_src       <= '0;
            conflict_cnt <= '0;
            for (int b = 0; b < NUM_BANK; b++) begin
                rr_ptr[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANK; b++) begin
                if (grant_any[b]) begin
                    bg_valid[b]                   <= 1'b1;
                    bg_addr[b*ADDR_W +: ADDR_W]   <= port_addr[grant_idx[b]];
                    bg_src[b*PORT_W +: PORT_W]    <= grant_idx[b];
                    rr_ptr[b] <= (grant_idx[b] == PORT_W'(NUM_PORT-1)) ?
                                 '0 : grant_idx[b] + PORT_W'(1);
                end else if (bg_ready[b]) begin
                    bg_valid[b] <= 1'b0;
                end
            end
            conflict_cnt <= (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        end
    end

endmodule
